// File: rtl/pong_sprite.sv
// 16x16 monochrome sprite renderer: holds position and bitmap base, latches one
// bitmap row per scan line and produces a registered per-pixel sprite_on.
module pong_sprite #(
    parameter logic [8:0] SPRITE_MEM_LOC = 9'h0a0,
    parameter int         XLOC_INITIAL   = 0,
    parameter int         YLOC_INITIAL   = 0,
    parameter int         SCALE          = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    input  logic        x_loc_en,
    input  logic        y_loc_en,
    input  logic        mem_addr_wren,
    input  logic        linebegin,
    input  logic [11:0] h_addr,
    input  logic [10:0] v_addr,
    input  logic        line_en,
    output logic        sprite_on,
    output logic [8:0]  mem_addr
);

    localparam int          SHIFT = $clog2(SCALE);
    localparam logic [12:0] SPAN  = 13'(16 * SCALE);

    logic [11:0] xloc;
    logic [10:0] yloc;
    logic [8:0]  base;
    logic [15:0] fetch;
    logic [15:0] disp;

    logic [11:0] dy;
    logic [11:0] yend;
    logic        vin;
    logic [3:0]  row;
    logic [11:0] dx;
    logic [12:0] xend;
    logic        hin;
    logic [3:0]  col;
    logic        wr_any;

    // Vertical band and row select; sums widened so the band never wraps.
    always_comb begin
        dy       = {1'b0, v_addr} - {1'b0, yloc};
        yend     = {1'b0, yloc} + SPAN[11:0];
        vin      = (v_addr >= yloc) && ({1'b0, v_addr} < yend);
        row      = 4'(dy >> SHIFT);
        mem_addr = base + {5'b0, row};
    end

    // Horizontal band and column select; right-edge sprites clip instead of wrapping.
    always_comb begin
        dx   = h_addr - xloc;
        xend = {1'b0, xloc} + SPAN;
        hin  = (h_addr >= xloc) && ({1'b0, h_addr} < xend);
        col  = 4'(dx >> SHIFT);
    end

    assign wr_any = x_loc_en | y_loc_en | mem_addr_wren;

    // Register writes share data_in, so any of them blocks a row fetch that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xloc  <= 12'(XLOC_INITIAL);
            yloc  <= 11'(YLOC_INITIAL);
            base  <= SPRITE_MEM_LOC & 9'h1f0;
            fetch <= 16'h0000;
        end else begin
            if (x_loc_en)
                xloc <= data_in[11:0];
            if (y_loc_en)
                yloc <= data_in[10:0];
            if (mem_addr_wren)
                base <= {data_in[8:4], 4'h0};
            if (line_en && !wr_any)
                fetch <= vin ? data_in : 16'h0000;
        end
    end

    // Display stage: committed row and registered pixel output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp      <= 16'h0000;
            sprite_on <= 1'b0;
        end else begin
            if (linebegin)
                disp <= fetch;
            sprite_on <= hin && disp[4'd15 - col];
        end
    end

endmodule

// File: tb/tb_pong_sprite.sv
// Scoreboard bench for pong_sprite: a behavioural model predicts sprite_on for each
// driven h_addr; predictions are queued and compared one cycle later.
module tb_pong_sprite;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic        x_loc_en, y_loc_en, mem_addr_wren, linebegin, line_en;
    logic [11:0] h_addr;
    logic [10:0] v_addr;
    logic        sprite_on;
    logic [8:0]  mem_addr;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int   h;
        logic e;
    } px_t;
    px_t exp_q[$];

    int          m_x, m_y;
    logic [8:0]  m_base;
    logic [15:0] m_fetch, m_disp;

    pong_sprite #(
        .SPRITE_MEM_LOC(9'h0b0),
        .XLOC_INITIAL  (50),
        .YLOC_INITIAL  (0),
        .SCALE         (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .x_loc_en     (x_loc_en),
        .y_loc_en     (y_loc_en),
        .mem_addr_wren(mem_addr_wren),
        .linebegin    (linebegin),
        .h_addr       (h_addr),
        .v_addr       (v_addr),
        .line_en      (line_en),
        .sprite_on    (sprite_on),
        .mem_addr     (mem_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_on(input int h);
        int c;
        if (h < m_x || h >= m_x + 64)
            return 1'b0;
        c = ((h - m_x) >> 2) & 15;
        return m_disp[15 - c];
    endfunction

    task automatic model_reset();
        m_x = 50; m_y = 0; m_base = 9'h0b0; m_fetch = 16'h0; m_disp = 16'h0;
    endtask

    task automatic drain();
        px_t p;
        if (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            check($sformatf("sprite_on h=%0d", p.h), {31'b0, sprite_on}, {31'b0, p.e});
        end
    endtask

    task automatic sweep(input int lo, input int hi);
        px_t p;
        for (int h = lo; h <= hi; h++) begin
            @(negedge clk);
            drain();
            h_addr = 12'(h);
            p.h = h;
            p.e = exp_on(h);
            exp_q.push_back(p);
        end
        @(negedge clk);
        drain();
    endtask

    // One-cycle control pulse; the model mirrors the behaviour at that clock edge.
    task automatic pulse(input logic xe, input logic ye, input logic me, input logic le,
                         input logic lb, input logic [15:0] d);
        logic        vin;
        logic [15:0] old_fetch;
        @(negedge clk);
        x_loc_en = xe; y_loc_en = ye; mem_addr_wren = me; line_en = le; linebegin = lb;
        data_in  = d;
        vin       = (int'(v_addr) >= m_y) && (int'(v_addr) < m_y + 64);
        old_fetch = m_fetch;
        if (le && !(xe || ye || me))
            m_fetch = vin ? d : 16'h0;
        if (lb)
            m_disp = old_fetch;
        if (xe) m_x = int'(d[11:0]);
        if (ye) m_y = int'(d[10:0]);
        if (me) m_base = {d[8:4], 4'h0};
        @(negedge clk);
        x_loc_en = 0; y_loc_en = 0; mem_addr_wren = 0; line_en = 0; linebegin = 0;
    endtask

    initial begin
        rst = 1'b1;
        data_in = 0; x_loc_en = 0; y_loc_en = 0; mem_addr_wren = 0;
        linebegin = 0; line_en = 0; h_addr = 0; v_addr = 11'd8;
        model_reset();
        #12;
        check("reset sprite_on", {31'b0, sprite_on}, 32'd0);
        check("reset mem_addr", {23'b0, mem_addr}, 32'h0b2);
        @(negedge clk);
        rst = 1'b0;
        sweep(0, 130);

        // Two-column row at x=100: pixels 100..103 and 160..163.
        pulse(1, 0, 0, 0, 0, 16'd100);
        v_addr = 11'd0;
        pulse(0, 0, 0, 1, 0, 16'h8001);
        pulse(0, 0, 0, 0, 1, 16'h0);
        sweep(95, 170);

        // Line just above the band fetches zeros.
        pulse(0, 1, 0, 0, 0, 16'd200);
        v_addr = 11'd199;
        pulse(0, 0, 0, 1, 0, 16'hFFFF);
        pulse(0, 0, 0, 0, 1, 16'h0);
        sweep(95, 170);

        // Last line of the band.
        v_addr = 11'd263;
        #1 check("mem_addr last row", {23'b0, mem_addr}, 32'h0bf);
        pulse(0, 0, 0, 1, 0, 16'hFFFF);
        pulse(0, 0, 0, 0, 1, 16'h0);
        sweep(95, 170);

        // First line below the band blanks again.
        v_addr = 11'd264;
        pulse(0, 0, 0, 1, 0, 16'hFFFF);
        pulse(0, 0, 0, 0, 1, 16'h0);
        sweep(95, 170);

        // Base write with low nibble forced to zero.
        pulse(0, 0, 1, 0, 0, 16'h0035);
        v_addr = 11'd200;
        #1 check("mem_addr new base", {23'b0, mem_addr}, 32'h030);

        // Restore a full row, then collide x_loc_en with line_en: fetch must hold.
        pulse(0, 0, 0, 1, 0, 16'hFFFF);
        pulse(1, 0, 0, 1, 0, 16'h0014);
        pulse(0, 0, 0, 0, 1, 16'h0);
        sweep(10, 90);

        // Right-edge clipping: no wrap back to low h_addr.
        pulse(1, 0, 0, 0, 0, 16'd4080);
        sweep(4070, 4095);
        sweep(0, 10);

        // Asynchronous reset while the sprite is lit.
        pulse(1, 0, 0, 0, 0, 16'd20);
        @(negedge clk);
        h_addr = 12'd30;
        @(posedge clk);
        #1 check("lit before reset", {31'b0, sprite_on}, 32'd1);
        #2 rst = 1'b1;
        #1 check("sprite_on at reset", {31'b0, sprite_on}, 32'd0);
        v_addr = 11'd8;
        #1 check("mem_addr after reset", {23'b0, mem_addr}, 32'h0b2);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        sweep(15, 120);
        v_addr = 11'd0;
        pulse(0, 0, 0, 1, 0, 16'hFFFF);
        pulse(0, 0, 0, 0, 1, 16'h0);
        sweep(40, 120);

        if (exp_q.size() != 0)
            check("scoreboard empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
